// File: rtl/imem_loader.sv
// Purpose : fills the instruction RAM from a framed host byte stream and holds the core in reset until a good image has landed.
// Latency : imem_we fires the cycle after the 4th byte of each word; sustained rate is one word per 5 cycles.
// Backpressure: rx_ready drops for exactly the one WRITE cycle per word; otherwise every byte is accepted.
//
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready     incoming byte stream (transfer = rx_valid & rx_ready)
//   imem_we/imem_addr/imem_wdata  IMEM write port, byte address, little-endian assembled word
//   cpu_hold                      1 = core held in reset (released only after a good load)
//   busy/done/err                 frame in progress / last image loaded / last frame rejected
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI (word count N), N*4 payload bytes LSB first, [CHK].
// Build option: define IMEM_LOADER_CHKSUM_EN to expect a trailing XOR checksum byte after the payload.

module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CAP_WORDS = 1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_DONE, ST_ERROR
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic        take;
    logic [15:0] len_full;

    assign rx_ready   = (state_q != ST_WRITE);
    assign take       = rx_valid & rx_ready;
    assign len_full   = {rx_data, len_q[7:0]};
    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERROR);

    always_comb begin
        busy = 1'b0;
        case (state_q)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE: busy = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHK:                                  busy = 1'b1;
`endif
            default:                                 busy = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // Anything but the sync marker is dropped so a host can resync mid-stream.
                if (take && rx_data == SYNC_BYTE) begin
                    state_d    = ST_LEN_LO;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    addr_d     = BASE_ADDR;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (take) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (take) begin
                    len_d[15:8] = rx_data;
                    if ({16'h0, len_full} > CAP_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (len_full == 16'h0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (take) begin
                    wdata_d[8*byte_cnt_q +: 8] = rx_data;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (word_idx_d == len_q) begin
                    // Address is left on the last written word so it never points past capacity.
`ifdef IMEM_LOADER_CHKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (take) begin
                    state_d = (rx_data == chk_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            wdata_q    <= '0;
            addr_q     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

endmodule
